dcache_controller: RTL and testbench

Synchronous controller for the direct-mapped data cache: holds tag/valid/data arrays, accepts single-word CPU reads and writes, and sequences the main-memory (MEM) handshake on misses and write-throughs. It sits between the CPU data port and MEM, with MEM's 4-word block read (`out`, `ready`) wired directly to this block. Policy: read-allocate, write-through, no-write-allocate.

---
 rtl/dcache_controller_if.sv | 31 +++
 rtl/dcache_controller.sv | 128 ++++++++++++
 tb/tb_dcache_controller.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dcache_controller_if.sv
// dcache_controller_if: CPU data port and MEM port bundle for dcache_controller.
interface dcache_controller_if #(
   parameter int ADR_W  = 15,
   parameter int DATA_W = 32
);
   logic                cpu_rd;
   logic                cpu_wr;
   logic [ADR_W-1:0]    cpu_adr;
   logic [DATA_W-1:0]   cpu_wdata;
   logic                cpu_busy;
   logic                cpu_ready;
   logic [DATA_W-1:0]   cpu_rdata;
   logic                mem_read;
   logic                mem_write;
   logic [ADR_W-1:0]    mem_adr;
   logic [DATA_W-1:0]   mem_wdata;
   logic                mem_ready;
   logic [4*DATA_W-1:0] mem_rdata;
   logic [15:0]         hit_cnt;
   logic [15:0]         miss_cnt;

   modport master (
      output cpu_rd, cpu_wr, cpu_adr, cpu_wdata, mem_ready, mem_rdata,
      input  cpu_busy, cpu_ready, cpu_rdata, mem_read, mem_write, mem_adr, mem_wdata, hit_cnt, miss_cnt
   );

   modport slave (
      input  cpu_rd, cpu_wr, cpu_adr, cpu_wdata, mem_ready, mem_rdata,
      output cpu_busy, cpu_ready, cpu_rdata, mem_read, mem_write, mem_adr, mem_wdata, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, read-allocate, write-through, no-write-allocate data cache.
// Hit/miss statistics are built only when DCACHE_STATS_EN is defined; otherwise both counters read 0.
module dcache_controller #(
   parameter int ADR_W     = 15,
   parameter int DATA_W    = 32,
   parameter int INDEX_W   = 10,
   parameter int WR_CYCLES = 12
) (
   input logic               clk,
   input logic               rst,
   dcache_controller_if.slave bus
);
   localparam int TAG_W = ADR_W - INDEX_W - 2;
   localparam int LINES = 1 << INDEX_W;
   localparam int CNT_W = $clog2(WR_CYCLES + 1);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] COMPARE = 3'd1;
   localparam logic [2:0] MEM_RD  = 3'd2;
   localparam logic [2:0] FILL    = 3'd3;
   localparam logic [2:0] RESPOND = 3'd4;
   localparam logic [2:0] MEM_WR  = 3'd5;

   logic [2:0]          r_state;
   logic [2:0]          w_next;
   logic [ADR_W-1:0]    r_adr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_wr;
   logic [CNT_W-1:0]    r_cnt;
   logic [LINES-1:0]    r_valid;
   logic [TAG_W-1:0]    r_tag  [LINES];
   logic [4*DATA_W-1:0] r_data [LINES];

   logic [1:0]          w_off;
   logic [INDEX_W-1:0]  w_idx;
   logic [TAG_W-1:0]    w_tag;
   logic                w_hit;
   logic [4*DATA_W-1:0] w_line;
   logic [DATA_W-1:0]   w_word;
   logic [DATA_W-1:0]   w_fill_word;
   logic                w_req;
   logic                w_wr_last;

   assign w_off       = r_adr[1:0];
   assign w_idx       = r_adr[INDEX_W+1:2];
   assign w_tag       = r_adr[ADR_W-1:INDEX_W+2];
   assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_line      = r_data[w_idx];
   assign w_word      = w_line[w_off*DATA_W +: DATA_W];
   assign w_fill_word = bus.mem_rdata[w_off*DATA_W +: DATA_W];
   assign w_req       = bus.cpu_rd || bus.cpu_wr;
   assign w_wr_last   = r_cnt == CNT_W'(WR_CYCLES - 1);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_req ? COMPARE : IDLE;
         COMPARE: w_next = r_wr ? MEM_WR : (w_hit ? RESPOND : MEM_RD);
         // r_cnt is 0 only in the first MEM_RD cycle, where ready may still be left over
         MEM_RD:  w_next = (r_cnt != '0 && bus.mem_ready) ? FILL : MEM_RD;
         FILL:    w_next = RESPOND;
         RESPOND: w_next = IDLE;
         MEM_WR:  w_next = w_wr_last ? IDLE : MEM_WR;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_adr   <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_wr    <= 1'b0;
         r_cnt   <= '0;
         r_valid <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_next != r_state) ? '0 : ((&r_cnt) ? r_cnt : r_cnt + 1'b1);
         if (r_state == IDLE && w_req) begin
            r_adr   <= bus.cpu_adr;
            r_wdata <= bus.cpu_wdata;
            r_wr    <= bus.cpu_wr;
         end
         if (r_state == COMPARE && !r_wr && w_hit)
            r_rdata <= w_word;
         if (r_state == FILL) begin
            r_rdata        <= w_fill_word;
            r_valid[w_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == FILL) begin
         r_tag[w_idx]  <= w_tag;
         r_data[w_idx] <= bus.mem_rdata;
      end else if (r_state == COMPARE && r_wr && w_hit)
         r_data[w_idx][w_off*DATA_W +: DATA_W] <= r_wdata;
   end

`ifdef DCACHE_STATS_EN
   logic [15:0] r_hit;
   logic [15:0] r_miss;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit  <= '0;
         r_miss <= '0;
      end else if (r_state == COMPARE) begin
         r_hit  <= (w_hit && r_hit != 16'hFFFF) ? r_hit + 16'd1 : r_hit;
         r_miss <= (!w_hit && r_miss != 16'hFFFF) ? r_miss + 16'd1 : r_miss;
      end
   end
   assign bus.hit_cnt  = r_hit;
   assign bus.miss_cnt = r_miss;
`else
   assign bus.hit_cnt  = '0;
   assign bus.miss_cnt = '0;
`endif

   assign bus.cpu_busy  = r_state != IDLE;
   assign bus.cpu_ready = (r_state == RESPOND) || (r_state == MEM_WR && w_wr_last);
   assign bus.cpu_rdata = r_rdata;
   assign bus.mem_read  = r_state == MEM_RD;
   assign bus.mem_write = r_state == MEM_WR;
   assign bus.mem_adr   = (r_state == MEM_WR) ? r_adr : {r_adr[ADR_W-1:2], 2'b00};
   assign bus.mem_wdata = r_wdata;
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed scoreboard bench for dcache_controller with a behavioural MEM.
module tb_dcache_controller;
`ifdef DCACHE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct packed {
      logic        is_rd;
      logic [31:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   int   mem_lat = 3;
   exp_t q[$];
   logic [31:0] wmem [int];

   dcache_controller_if #(.ADR_W(15), .DATA_W(32)) bus();
   dcache_controller dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [14:0] a);
      return wmem.exists(int'(a)) ? wmem[int'(a)] : (32'hC0DE0000 | {17'd0, a});
   endfunction

   // MEM model: absorbs write-throughs, answers block reads after mem_lat cycles
   initial begin
      int lat_cnt;
      lat_cnt = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.mem_write) wmem[int'(bus.mem_adr)] = bus.mem_wdata;
         if (bus.mem_read) begin
            lat_cnt++;
            if (lat_cnt >= mem_lat) begin
               for (int w = 0; w < 4; w++)
                  bus.mem_rdata[w*32 +: 32] = mem_word({bus.mem_adr[14:2], 2'(w)});
               bus.mem_ready = 1'b1;
            end
         end else begin
            lat_cnt = 0;
            bus.mem_ready = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (bus.cpu_ready) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_ready: got cpu_ready=1 expected no pending request");
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.is_rd) check("cpu_rdata", bus.cpu_rdata, e.d);
         end
      end
   end

   task automatic do_req(input bit rd, input bit wr, input logic [14:0] adr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input bit pulse,
                         output int lat, output int rdc, output int wrc, output int bad);
      q.push_back('{is_rd: !wr, d: exp_rd});
      lat = 0; rdc = 0; wrc = 0; bad = 0;
      @(negedge clk);
      bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_adr = adr; bus.cpu_wdata = wd;
      @(negedge clk);
      bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         if (i > 1) @(negedge clk);
         if (bus.mem_read) begin
            rdc++;
            if (bus.mem_adr !== {adr[14:2], 2'b00}) bad++;
         end
         if (bus.mem_write) begin
            wrc++;
            if (bus.mem_adr !== adr || bus.mem_wdata !== wd) bad++;
         end
         bus.cpu_rd = pulse && (i == 3);
         if (bus.cpu_ready) begin
            lat = i;
            break;
         end
      end
      bus.cpu_rd = 1'b0;
      if (lat == 0) check("timeout", 32'd0, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic req(input string tag, input bit wr, input logic [14:0] adr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input int exp_lat, input int exp_rdc, input int exp_wrc,
                      input bit pulse);
      int lat, rdc, wrc, bad;
      do_req(!wr | pulse, wr, adr, wd, exp_rd, pulse, lat, rdc, wrc, bad);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_memrd_cycles"}, rdc, exp_rdc);
      check({tag, "_memwr_cycles"}, wrc, exp_wrc);
      check({tag, "_mem_bus"}, bad, 0);
   endtask

   task automatic counters(input string tag, input logic [15:0] h, input logic [15:0] m);
      check({tag, "_hit_cnt"}, {16'd0, bus.hit_cnt}, STATS ? {16'd0, h} : 32'd0);
      check({tag, "_miss_cnt"}, {16'd0, bus.miss_cnt}, STATS ? {16'd0, m} : 32'd0);
   endtask

   initial begin
      bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_adr = '0; bus.cpu_wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", bus.cpu_busy, 0);
      check("rst_ready", bus.cpu_ready, 0);
      check("rst_mem_read", bus.mem_read, 0);
      check("rst_mem_write", bus.mem_write, 0);
      check("rst_rdata", bus.cpu_rdata, 0);
      check("rst_mem_adr", bus.mem_adr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      counters("rst", 0, 0);
      rst = 1'b0;

      req("rd1050_miss", 0, 15'd1050, 0, 32'hC0DE041A, 6, 3, 0, 0);
      counters("after_1050", 0, 1);
      req("rd1049_hit", 0, 15'd1049, 0, 32'hC0DE0419, 2, 0, 0, 0);
      counters("after_1049", 1, 1);
      req("rd5146_miss", 0, 15'd5146, 0, 32'hC0DE141A, 6, 3, 0, 0);
      req("rd1050_remiss", 0, 15'd1050, 0, 32'hC0DE041A, 6, 3, 0, 0);
      counters("after_replace", 1, 3);
      req("wr1051_hit", 1, 15'd1051, 32'hDEADBEEF, 0, 13, 0, 12, 0);
      req("rd1051_hit", 0, 15'd1051, 0, 32'hDEADBEEF, 2, 0, 0, 0);
      req("wr40_miss", 1, 15'd40, 32'h12345678, 0, 13, 0, 12, 0);
      req("rd40_miss", 0, 15'd40, 0, 32'h12345678, 6, 3, 0, 0);
      counters("after_writes", 3, 5);
      req("rdwr1050", 1, 15'd1050, 32'hCAFEF00D, 0, 13, 0, 12, 1);
      req("rd1050_new", 0, 15'd1050, 0, 32'hCAFEF00D, 2, 0, 0, 0);
      counters("after_both", 5, 5);

      // reset while a miss is waiting on MEM
      mem_lat = 1000;
      @(negedge clk);
      bus.cpu_rd = 1'b1; bus.cpu_adr = 15'd5146;
      @(negedge clk);
      bus.cpu_rd = 1'b0;
      @(negedge clk);
      check("pre_rst_mem_read", bus.mem_read, 1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_mem_read", bus.mem_read, 0);
      check("midrst_mem_write", bus.mem_write, 0);
      check("midrst_busy", bus.cpu_busy, 0);
      check("midrst_ready", bus.cpu_ready, 0);
      counters("midrst", 0, 0);
      rst = 1'b0;
      mem_lat = 3;
      req("rd1049_after_rst", 0, 15'd1049, 0, 32'hC0DE0419, 6, 3, 0, 0);
      counters("after_rst", 0, 1);

      check("scoreboard_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
